// File: rtl/peq_pkg.sv
// peq_pkg: shared frame-state type and gain-apply arithmetic helpers
// used by gcapply and gcmul.
package peq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CURVE,
    BYPASS
  } frame_st_e;

  // Unity gain in unsigned Q1.(w-1).
  function automatic logic [63:0] unity_gain(
    input int w
  );
    return 64'd1 << (w - 1);
  endfunction

  // Round half up, then arithmetic shift down by w-1.
  function automatic logic signed [63:0] rnd_shift(
    input logic signed [63:0] p,
    input int                 w
  );
    return (p + (64'sd1 <<< (w - 2))) >>> (w - 1);
  endfunction

  // Round as above, then clamp to the signed w-bit range.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] p,
    input int                 w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = rnd_shift(p, w);
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/gcmul.sv
// gcmul: signed x unsigned-gain multiply (S2) with round/saturate (S3).
// Ports: clk, rst, vld (S1 strobe), x, g -> y; clip (GCAPPLY_CLIPCNT_EN only).
module gcmul
  import peq_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld,
  input  logic signed [AW-1:0] x,
  input  logic        [AW-1:0] g,
  output logic signed [AW-1:0] y
`ifdef GCAPPLY_CLIPCNT_EN
  ,
  output logic                 clip
`endif
);

  logic signed [2*AW:0] xe;
  logic signed [2*AW:0] ge;
  logic signed [2*AW:0] p;
  logic signed [63:0]   pext;
  logic                 v2;

  assign xe   = {{(AW + 1){x[AW-1]}}, x};
  assign ge   = $signed({(AW + 1)'(0), g});
  assign pext = $signed({{(63 - 2 * AW){p[2*AW]}}, p});

`ifdef GCAPPLY_CLIPCNT_EN
  // Flags the sample currently in S2, ahead of its output register.
  assign clip = sat_round(pext, AW) != rnd_shift(pext, AW);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p  <= '0;
      v2 <= 1'b0;
      y  <= '0;
    end else begin
      v2 <= vld;
      if (vld) p <= xe * ge;
      if (v2) y <= AW'(sat_round(pext, AW));
    end
  end

endmodule

// File: rtl/gcapply.sv
// gcapply: scales each FFT bin by the stored gain curve, 3-cycle latency.
// Ports: in_* bin stream, gcurve_addr/dout curve RAM, out_* scaled stream,
// curve_active, idx_err; clip_count when GCAPPLY_CLIPCNT_EN is defined.
module gcapply
  import peq_pkg::*;
#(
  parameter int LOGFFTSIZE = 11,
  parameter int AUDIOWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic        [LOGFFTSIZE-1:0] in_index,
  input  logic signed [AUDIOWIDTH-1:0] in_re,
  input  logic signed [AUDIOWIDTH-1:0] in_im,
  input  logic                         recompute_done,
  output logic        [LOGFFTSIZE-1:0] gcurve_addr,
  input  logic        [AUDIOWIDTH-1:0] gcurve_dout,
  output logic                         out_valid,
  output logic        [LOGFFTSIZE-1:0] out_index,
  output logic signed [AUDIOWIDTH-1:0] out_re,
  output logic signed [AUDIOWIDTH-1:0] out_im,
  output logic                         curve_active,
  output logic                         idx_err
`ifdef GCAPPLY_CLIPCNT_EN
  ,
  output logic                  [15:0] clip_count
`endif
);

  localparam int LF = LOGFFTSIZE;
  localparam int AW = AUDIOWIDTH;
  localparam logic [AW-1:0] UNITY =
    AW'(unity_gain(AW));
  localparam logic [LF-1:0] LAST = '1;

  frame_st_e          st;
  frame_st_e          st_n;
  logic      [LF-1:0] exp_q;
  logic      [LF-1:0] exp_n;
  logic               seq_ok;
  logic               fstart;
  logic               byp;
  logic               err_set;

  logic signed [AW-1:0] s1_re;
  logic signed [AW-1:0] s1_im;
  logic        [LF-1:0] s1_idx;
  logic                 s1_vld;
  logic                 s1_cur;
  logic        [AW-1:0] gain;
  logic        [LF-1:0] s2_idx;
  logic                 s2_vld;
  logic                 s2_cur;

  assign gcurve_addr = in_index;

  assign seq_ok = in_valid && (st != IDLE) &&
                  (in_index == exp_q);
  assign fstart = in_valid && !seq_ok &&
                  (in_index == '0);

  // Any index mismatch drops to IDLE; an index 0
  // restarts a frame exactly as it would from IDLE.
  always_comb begin
    st_n    = st;
    exp_n   = exp_q;
    byp     = 1'b1;
    err_set = 1'b0;
    unique case (1'b1)
      !in_valid: ;
      seq_ok: begin
        byp   = (st == BYPASS) || !recompute_done;
        exp_n = exp_q + 1'b1;
        if (in_index == LAST) st_n = IDLE;
        else st_n = byp ? BYPASS : CURVE;
      end
      fstart: begin
        err_set = (st != IDLE);
        byp     = !recompute_done;
        st_n    = recompute_done ? CURVE : BYPASS;
        exp_n   = LF'(1);
      end
      default: begin
        err_set = (st != IDLE);
        st_n    = IDLE;
      end
    endcase
  end

  assign gain = s1_cur ? gcurve_dout : UNITY;

`ifdef GCAPPLY_CLIPCNT_EN
  logic c_re;
  logic c_im;
`endif

  gcmul #(.AW(AW)) u_mul_re (
    .clk (clk),
    .rst (rst),
    .vld (s1_vld),
    .x   (s1_re),
    .g   (gain),
    .y   (out_re)
`ifdef GCAPPLY_CLIPCNT_EN
    ,
    .clip(c_re)
`endif
  );

  gcmul #(.AW(AW)) u_mul_im (
    .clk (clk),
    .rst (rst),
    .vld (s1_vld),
    .x   (s1_im),
    .g   (gain),
    .y   (out_im)
`ifdef GCAPPLY_CLIPCNT_EN
    ,
    .clip(c_im)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      exp_q        <= '0;
      idx_err      <= 1'b0;
      s1_vld       <= 1'b0;
      s1_re        <= '0;
      s1_im        <= '0;
      s1_idx       <= '0;
      s1_cur       <= 1'b0;
      s2_vld       <= 1'b0;
      s2_idx       <= '0;
      s2_cur       <= 1'b0;
      out_valid    <= 1'b0;
      out_index    <= '0;
      curve_active <= 1'b0;
    end else begin
      st     <= st_n;
      exp_q  <= exp_n;
      if (err_set) idx_err <= 1'b1;
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_re  <= in_re;
        s1_im  <= in_im;
        s1_idx <= in_index;
        s1_cur <= !byp;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_idx <= s1_idx;
        s2_cur <= s1_cur;
      end
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_index    <= s2_idx;
        curve_active <= s2_cur;
      end
    end
  end

`ifdef GCAPPLY_CLIPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (fstart) begin
      clip_count <= '0;
    end else if (s2_vld && (c_re || c_im) &&
                 (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcapply.sv
// tb_gcapply: directed bench for gcapply, LOGFFTSIZE=4, AUDIOWIDTH=16.
// Drives bins on negedge, checks outputs 1 time unit after posedge.
module tb_gcapply;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic        [3:0]  in_index = '0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               recompute_done = 1'b0;
  logic        [3:0]  gcurve_addr;
  logic        [15:0] gcurve_dout = '0;
  logic               out_valid;
  logic        [3:0]  out_index;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic               curve_active;
  logic               idx_err;
`ifdef GCAPPLY_CLIPCNT_EN
  logic        [15:0] clip_count;
`endif

  gcapply #(.LOGFFTSIZE(4), .AUDIOWIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_index      (in_index),
    .in_re         (in_re),
    .in_im         (in_im),
    .recompute_done(recompute_done),
    .gcurve_addr   (gcurve_addr),
    .gcurve_dout   (gcurve_dout),
    .out_valid     (out_valid),
    .out_index     (out_index),
    .out_re        (out_re),
    .out_im        (out_im),
    .curve_active  (curve_active),
    .idx_err       (idx_err)
`ifdef GCAPPLY_CLIPCNT_EN
    ,
    .clip_count    (clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        [3:0]  idx;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               cur;
    longint             t;
  } exp_t;

  exp_t        q[$];
  exp_t        m;
  logic [15:0] ram[16];
  longint      cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  always @(posedge clk) gcurve_dout <= ram[gcurve_addr];
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input longint got,
                       input longint want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        m = q.pop_front();
        check("out_index", out_index, m.idx);
        check("out_re", out_re, m.re);
        check("out_im", out_im, m.im);
        check("curve_active", curve_active, m.cur);
        check("latency", cyc - m.t, 3);
      end
    end
  end

  task automatic send(input int idx, input int re,
                      input int im, input logic done,
                      input int ere, input int eim,
                      input logic ecur);
    exp_t e;
    @(negedge clk);
    in_valid       = 1'b1;
    in_index       = 4'(idx);
    in_re          = 16'(re);
    in_im          = 16'(im);
    recompute_done = done;
    e.idx = 4'(idx);
    e.re  = 16'(ere);
    e.im  = 16'(eim);
    e.cur = ecur;
    e.t   = cyc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic fill(input logic [15:0] g);
    for (int i = 0; i < 16; i++) ram[i] = g;
  endtask

  initial begin
    fill(16'd0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_index", out_index, 0);
    check("rst_curve_active", curve_active, 0);
    check("rst_idx_err", idx_err, 0);
`ifdef GCAPPLY_CLIPCNT_EN
    check("rst_clip_count", clip_count, 0);
`endif
    rst = 1'b0;

    // Half-gain curve, full frame.
    fill(16'd16384);
    for (int i = 0; i < 16; i++)
      send(i, 1000, -1000, 1'b1, 500, -500, 1'b1);
    idle(6);
`ifdef GCAPPLY_CLIPCNT_EN
    check("clip_count_none", clip_count, 0);
`endif

    // Near-2x curve: saturation and rounding.
    fill(16'hFFFF);
    send(0, 30000, -32768, 1'b1, 32767, -32768, 1'b1);
    send(1, -3, 5, 1'b1, -6, 10, 1'b1);
    for (int i = 2; i < 16; i++)
      send(i, 0, 0, 1'b1, 0, 0, 1'b1);
    idle(6);
`ifdef GCAPPLY_CLIPCNT_EN
    check("clip_count_one", clip_count, 1);
`endif

    // Bypass frame; done rising mid-frame is ignored.
    fill(16'd0);
    for (int i = 0; i < 16; i++)
      send(i, i * 100 + 7, -i * 50 - 3, i >= 5,
           i * 100 + 7, -i * 50 - 3, 1'b0);
    idle(4);

    // Done falls at index 7, next frame stays bypassed.
    fill(16'd16384);
    for (int i = 0; i < 16; i++)
      send(i, 1000, -1000, i < 7,
           (i < 7) ? 500 : 1000,
           (i < 7) ? -500 : -1000, i < 7);
    for (int i = 0; i < 16; i++)
      send(i, 1000, -1000, i >= 3,
           1000, -1000, 1'b0);
    idle(6);
    check("idx_err_clean", idx_err, 0);

    // Sequence error 0,1,2,5 then recovery.
    send(0, 1000, -1000, 1'b1, 500, -500, 1'b1);
    send(1, 1000, -1000, 1'b1, 500, -500, 1'b1);
    send(2, 1000, -1000, 1'b1, 500, -500, 1'b1);
    send(5, 1000, -1000, 1'b1, 1000, -1000, 1'b0);
    idle(5);
    check("idx_err_set", idx_err, 1);
    for (int i = 0; i < 16; i++)
      send(i, -2000, 2000, 1'b1, -1000, 1000, 1'b1);
    idle(6);
    check("idx_err_sticky", idx_err, 1);

    // Reset mid-frame.
    for (int i = 0; i < 6; i++)
      send(i, 1000, -1000, 1'b1, 500, -500, 1'b1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_idx_err", idx_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(3, 1000, -1000, 1'b1, 1000, -1000, 1'b0);
    send(4, 1000, -1000, 1'b1, 1000, -1000, 1'b0);
    for (int i = 0; i < 16; i++)
      send(i, 1000, -1000, 1'b1, 500, -500, 1'b1);
    idle(6);
    check("postrst_idx_err", idx_err, 0);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
